// File: rtl/uart_text_console_if.sv
// Bundle between the UART receiver / LCD VRAM port and the text console.
// master = receiver and display side, slave = the console itself.
interface uart_text_console_if #(
   parameter int ADDR_W = 12
);
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              overflow;
   logic              vram_ce;
   logic [ADDR_W-1:0] vram_addr;
   logic [15:0]       vram_data;
   logic [7:0]        cursor_col;
   logic [7:0]        cursor_row;
   logic [7:0]        row_base;
   logic              busy;

   modport master (
      output rx_data, rx_ready,
      input  overflow, vram_ce, vram_addr, vram_data,
             cursor_col, cursor_row, row_base, busy
   );

   modport slave (
      input  rx_data, rx_ready,
      output overflow, vram_ce, vram_addr, vram_data,
             cursor_col, cursor_row, row_base, busy
   );
endinterface

// File: rtl/uart_text_console.sv
// Text console: buffers UART bytes in a FIFO and writes {ATTR,char} cells into VRAM at a cursor.
// Define CONSOLE_SCROLL_EN to get hardware scroll (row_base advance plus bottom-row clear) on the last row.
module uart_text_console #(
   parameter int         COLS       = 50,
   parameter int         ROWS       = 15,
   parameter int         ADDR_W     = 12,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] ATTR       = 8'hF0,
   parameter logic [7:0] BLANK      = 8'h20
) (
   input logic                clk_72m,
   input logic                reset,
   uart_text_console_if.slave bus
);
   localparam int                PW        = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
   localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
   localparam logic [7:0]        LAST_ROW  = 8'(ROWS - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, EXEC, ROWCLR} state_t;
   state_t state, next_state;

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       fifo_cnt;
   logic              fifo_full, fifo_empty, push, pop;

   logic [7:0]        cur_byte, col_q, row_q, base_q, nxt_col, nxt_row;
   logic [ADDR_W-1:0] cnt_q, nxt_cnt, row_addr, wr_addr;
   logic [8:0]        row_sum, phys_row;
   logic              wr_en, do_nl;
   logic [7:0]        wr_char;

   logic              vram_ce_q, overflow_q, busy_q;
   logic [ADDR_W-1:0] vram_addr_q;
   logic [15:0]       vram_data_q;

   assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt == '0);
   assign push       = bus.rx_ready && !fifo_full;

   // FIFO bookkeeping; a byte offered while full is dropped and flagged
   always_ff @(posedge clk_72m or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= bus.rx_ready && fifo_full;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      fifo_cnt <= fifo_cnt + (PW+1)'(1);
         else if (pop && !push) fifo_cnt <= fifo_cnt - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk_72m) begin
      if (push) fifo_mem[wr_ptr] <= bus.rx_data;
   end

   // Logical row to physical row without a divider: the sum is below 2*ROWS
   assign row_sum  = {1'b0, base_q} + {1'b0, row_q};
   assign phys_row = (row_sum >= 9'(ROWS)) ? (row_sum - 9'(ROWS)) : row_sum;
   assign row_addr = ADDR_W'(phys_row) * ADDR_W'(COLS);

`ifdef CONSOLE_SCROLL_EN
   logic [7:0] nxt_base;
`else
   assign base_q = 8'd0;
`endif

   always_comb begin
      next_state = state;
      nxt_col    = col_q;
      nxt_row    = row_q;
      nxt_cnt    = cnt_q;
`ifdef CONSOLE_SCROLL_EN
      nxt_base   = base_q;
`endif
      wr_en      = 1'b0;
      wr_addr    = row_addr + ADDR_W'(col_q);
      wr_char    = cur_byte;
      pop        = 1'b0;
      do_nl      = 1'b0;
      case (state)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_char = BLANK;
            nxt_col = 8'd0;
            nxt_row = 8'd0;
            if (cnt_q == LAST_CELL) begin
               nxt_cnt    = '0;
               next_state = IDLE;
            end else begin
               nxt_cnt = cnt_q + ADDR_W'(1);
            end
         end
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            next_state = IDLE;
            if (cur_byte >= 8'h20 && cur_byte <= 8'h7E) begin
               wr_en = 1'b1;
               if (col_q == LAST_COL) do_nl = 1'b1;
               else                   nxt_col = col_q + 8'd1;
            end else begin
               case (cur_byte)
                  8'h0D: nxt_col = 8'd0;
                  8'h0A: do_nl = 1'b1;
                  8'h08: begin
                     if (col_q != 8'd0) begin
                        nxt_col = col_q - 8'd1;
                        wr_en   = 1'b1;
                        wr_char = BLANK;
                        wr_addr = row_addr + ADDR_W'(col_q - 8'd1);
                     end
                  end
                  8'h0C: begin
`ifdef CONSOLE_SCROLL_EN
                     nxt_base   = 8'd0;
`endif
                     nxt_col    = 8'd0;
                     nxt_row    = 8'd0;
                     nxt_cnt    = '0;
                     next_state = CLEAR;
                  end
                  default: ;
               endcase
            end
            if (do_nl) begin
               nxt_col = 8'd0;
               if (row_q != LAST_ROW) begin
                  nxt_row = row_q + 8'd1;
               end else begin
`ifdef CONSOLE_SCROLL_EN
                  nxt_base   = (base_q == LAST_ROW) ? 8'd0 : base_q + 8'd1;
                  nxt_cnt    = '0;
                  next_state = ROWCLR;
`else
                  nxt_row = 8'd0;
`endif
               end
            end
         end
`ifdef CONSOLE_SCROLL_EN
         // row_base has already advanced, so the cursor row now maps onto the stale physical row
         ROWCLR: begin
            wr_en   = 1'b1;
            wr_addr = row_addr + cnt_q;
            wr_char = BLANK;
            if (cnt_q == ADDR_W'(LAST_COL)) begin
               nxt_cnt    = '0;
               next_state = IDLE;
            end else begin
               nxt_cnt = cnt_q + ADDR_W'(1);
            end
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_72m or negedge reset) begin
      if (!reset) begin
         state       <= CLEAR;
         col_q       <= 8'd0;
         row_q       <= 8'd0;
         cnt_q       <= '0;
         cur_byte    <= 8'd0;
         vram_ce_q   <= 1'b0;
         vram_addr_q <= '0;
         vram_data_q <= 16'd0;
         busy_q      <= 1'b1;
      end else begin
         state     <= next_state;
         col_q     <= nxt_col;
         row_q     <= nxt_row;
         cnt_q     <= nxt_cnt;
         vram_ce_q <= wr_en;
         busy_q    <= (state == CLEAR) || (state == ROWCLR);
         if (pop) cur_byte <= fifo_mem[rd_ptr];
         if (wr_en) begin
            vram_addr_q <= wr_addr;
            vram_data_q <= {ATTR, wr_char};
         end
      end
   end

`ifdef CONSOLE_SCROLL_EN
   always_ff @(posedge clk_72m or negedge reset) begin
      if (!reset) base_q <= 8'd0;
      else        base_q <= nxt_base;
   end
`endif

   assign bus.overflow   = overflow_q;
   assign bus.vram_ce    = vram_ce_q;
   assign bus.vram_addr  = vram_addr_q;
   assign bus.vram_data  = vram_data_q;
   assign bus.cursor_col = col_q;
   assign bus.cursor_row = row_q;
   assign bus.row_base   = base_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_text_console.sv
// Directed bench for uart_text_console: clear, printing, control codes, last-row newline, overflow, reset.
module tb_uart_text_console;
   localparam int CELLS = 750;

   logic clk_72m = 1'b0;
   logic reset   = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   ovf_cnt    = 0;
   int   last_push  = 0;
   int   wb, ob, err;

   logic [11:0] wq_addr [$];
   logic [15:0] wq_data [$];
   int          wq_cyc  [$];

   uart_text_console_if #(.ADDR_W(12)) bus ();

   uart_text_console dut (
      .clk_72m (clk_72m),
      .reset   (reset),
      .bus     (bus.slave)
   );

   always #5 clk_72m = ~clk_72m;

   always @(posedge clk_72m) cyc <= cyc + 1;

   // Record every VRAM write and overflow cycle, sampled mid-cycle
   always @(negedge clk_72m) begin
      if (bus.vram_ce === 1'b1) begin
         wq_addr.push_back(bus.vram_addr);
         wq_data.push_back(bus.vram_data);
         wq_cyc.push_back(cyc);
      end
      if (bus.overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared = compared + 1;
      assert (observed === expected) else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_72m);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk_72m);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      @(posedge clk_72m);
      #1;
      last_push    = cyc;
      bus.rx_ready = 1'b0;
      waitCycles(1);
   endtask

   task automatic floodByte(input logic [7:0] b);
      @(negedge clk_72m);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      @(posedge clk_72m);
      #1;
      bus.rx_ready = 1'b0;
   endtask

   task automatic waitWrites(input int target, input int bound);
      for (int i = 0; i < bound && wq_addr.size() < target; i++) waitCycles(1);
   endtask

   task automatic checkClear(input string tag, input int base);
      int e = 0;
      for (int i = 0; i < CELLS; i++)
         if (base + i >= wq_addr.size() || wq_addr[base+i] !== 12'(i) || wq_data[base+i] !== 16'hF020) e++;
      checkOutput(tag, e, 0);
   endtask

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_ready = 1'b0;

      // Reset state
      waitCycles(3);
      checkOutput("rst_vram_ce",   bus.vram_ce, 1'b0);
      checkOutput("rst_vram_addr", bus.vram_addr, 12'd0);
      checkOutput("rst_vram_data", bus.vram_data, 16'd0);
      checkOutput("rst_busy",      bus.busy, 1'b1);
      checkOutput("rst_overflow",  bus.overflow, 1'b0);
      checkOutput("rst_cursor",    {bus.cursor_col, bus.cursor_row, bus.row_base}, 24'd0);

      // Power-up clear
      reset = 1'b1;
      waitWrites(CELLS, 1000);
      checkOutput("clr_count", wq_addr.size(), CELLS);
      checkClear("clr_pattern", 0);
      waitCycles(5);
      checkOutput("clr_busy_low", bus.busy, 1'b0);
      checkOutput("clr_quiet", wq_addr.size(), CELLS);

      // "AB" with first-write latency
      wb = wq_addr.size();
      applyStimulus(8'h41);
      ob = last_push;
      applyStimulus(8'h42);
      waitCycles(6);
      checkOutput("ab_count", wq_addr.size(), wb + 2);
      checkOutput("ab_latency", wq_cyc[wb], ob + 2);
      checkOutput("ab_first", {4'd0, wq_addr[wb], wq_data[wb]}, {16'd0, 16'hF041});
      checkOutput("ab_second", {4'd0, wq_addr[wb+1], wq_data[wb+1]}, {16'd1, 16'hF042});
      checkOutput("ab_cursor", {bus.cursor_col, bus.cursor_row}, {8'd2, 8'd0});

      // Form feed back to a blank screen
      wb = wq_addr.size();
      applyStimulus(8'h0C);
      waitWrites(wb + CELLS, 1000);
      waitCycles(3);
      checkClear("ff_pattern", wb);
      checkOutput("ff_cursor", {bus.cursor_col, bus.cursor_row}, 16'd0);

      // 50 'x' wrap onto row 1, then 'y'
      wb = wq_addr.size();
      for (int i = 0; i < 50; i++) applyStimulus(8'h78);
      applyStimulus(8'h79);
      waitWrites(wb + 51, 100);
      waitCycles(3);
      err = 0;
      for (int i = 0; i < 50; i++)
         if (wq_addr[wb+i] !== 12'(i) || wq_data[wb+i] !== 16'hF078) err++;
      checkOutput("wrap_x_run", err, 0);
      checkOutput("wrap_y", {4'd0, wq_addr[wb+50], wq_data[wb+50]}, {16'd50, 16'hF079});
      checkOutput("wrap_cursor", {bus.cursor_col, bus.cursor_row}, {8'd1, 8'd1});

      // CR, LF, 'z'
      wb = wq_addr.size();
      applyStimulus(8'h0D);
      applyStimulus(8'h0A);
      applyStimulus(8'h7A);
      waitCycles(4);
      checkOutput("crlf_count", wq_addr.size(), wb + 1);
      checkOutput("crlf_z", {4'd0, wq_addr[wb], wq_data[wb]}, {16'd100, 16'hF07A});
      checkOutput("crlf_cursor", {bus.cursor_col, bus.cursor_row}, {8'd1, 8'd2});

      // Walk the cursor to (0,14), then newline on the last row
      applyStimulus(8'h0D);
      for (int i = 0; i < 12; i++) applyStimulus(8'h0A);
      waitCycles(3);
      checkOutput("last_row_cursor", {bus.cursor_col, bus.cursor_row}, {8'd0, 8'd14});
      wb = wq_addr.size();
      applyStimulus(8'h0A);
      applyStimulus(8'h71);
`ifdef CONSOLE_SCROLL_EN
      waitWrites(wb + 51, 300);
      waitCycles(5);
      checkOutput("scroll_count", wq_addr.size(), wb + 51);
      err = 0;
      for (int i = 0; i < 50; i++)
         if (wq_addr[wb+i] !== 12'(i) || wq_data[wb+i] !== 16'hF020) err++;
      checkOutput("scroll_rowclr", err, 0);
      checkOutput("scroll_q", {4'd0, wq_addr[wb+50], wq_data[wb+50]}, {16'd0, 16'hF071});
      checkOutput("scroll_base", bus.row_base, 8'd1);
      checkOutput("scroll_cursor", {bus.cursor_col, bus.cursor_row}, {8'd1, 8'd14});
`else
      waitWrites(wb + 1, 100);
      waitCycles(5);
      checkOutput("wrap_row_count", wq_addr.size(), wb + 1);
      checkOutput("wrap_row_q", {4'd0, wq_addr[wb], wq_data[wb]}, {16'd0, 16'hF071});
      checkOutput("wrap_row_base", bus.row_base, 8'd0);
      checkOutput("wrap_row_cursor", {bus.cursor_col, bus.cursor_row}, {8'd1, 8'd0});
`endif

      // Form feed resets row_base, then "ab", BS x3 and an ignored control byte
      wb = wq_addr.size();
      applyStimulus(8'h0C);
      waitWrites(wb + CELLS, 1000);
      waitCycles(3);
      checkClear("ff2_pattern", wb);
      checkOutput("ff2_base", bus.row_base, 8'd0);
      wb = wq_addr.size();
      applyStimulus(8'h61);
      applyStimulus(8'h62);
      applyStimulus(8'h08);
      applyStimulus(8'h08);
      applyStimulus(8'h08);
      applyStimulus(8'h01);
      waitCycles(6);
      checkOutput("bs_count", wq_addr.size(), wb + 4);
      checkOutput("bs_a", {4'd0, wq_addr[wb], wq_data[wb]}, {16'd0, 16'hF061});
      checkOutput("bs_b", {4'd0, wq_addr[wb+1], wq_data[wb+1]}, {16'd1, 16'hF062});
      checkOutput("bs_first", {4'd0, wq_addr[wb+2], wq_data[wb+2]}, {16'd1, 16'hF020});
      checkOutput("bs_second", {4'd0, wq_addr[wb+3], wq_data[wb+3]}, {16'd0, 16'hF020});
      checkOutput("bs_cursor", {bus.cursor_col, bus.cursor_row}, 16'd0);

      // 20 bytes arriving during a clear into a 16-entry FIFO
      wb = wq_addr.size();
      ob = ovf_cnt;
      applyStimulus(8'h0C);
      waitCycles(3);
      checkOutput("ovf_busy", bus.busy, 1'b1);
      for (int i = 0; i < 20; i++) floodByte(8'(8'h41 + i));
      waitWrites(wb + CELLS + 16, 1500);
      waitCycles(10);
      checkOutput("ovf_pulses", ovf_cnt - ob, 4);
      checkOutput("ovf_count", wq_addr.size(), wb + CELLS + 16);
      checkClear("ovf_clear", wb);
      err = 0;
      for (int i = 0; i < 16; i++)
         if (wq_addr[wb+CELLS+i] !== 12'(i) || wq_data[wb+CELLS+i] !== {8'hF0, 8'(8'h41 + i)}) err++;
      checkOutput("ovf_order", err, 0);
      checkOutput("ovf_cursor", {bus.cursor_col, bus.cursor_row}, {8'd16, 8'd0});

      // Reset mid-operation with bytes pending
      floodByte(8'h72);
      floodByte(8'h73);
      reset = 1'b0;
      #1;
      wb = wq_addr.size();
      checkOutput("mid_rst_ce", bus.vram_ce, 1'b0);
      checkOutput("mid_rst_busy", bus.busy, 1'b1);
      checkOutput("mid_rst_cursor", {bus.cursor_col, bus.cursor_row}, 16'd0);
      waitCycles(3);
      reset = 1'b1;
      waitWrites(wb + CELLS, 1000);
      waitCycles(20);
      checkOutput("mid_rst_count", wq_addr.size(), wb + CELLS);
      checkClear("mid_rst_clear", wb);
      checkOutput("mid_rst_idle", bus.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
